// File: rtl/otter_pkg.sv
// Types and constants shared by the OTTER control unit and decoder.
package otter_pkg;

  typedef enum logic [6:0] {
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    SYS    = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    INIT,
    FETCH,
    EXEC,
    WB,
    INTR
  } state_t;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;
  localparam logic [2:0] F3_CSRRC = 3'b011;

  // True for the three CSR read/modify/write forms that also write rd.
  function automatic logic is_csr_rw(input logic [2:0] f3);
    return (f3 == F3_CSRRW) || (f3 == F3_CSRRS) || (f3 == F3_CSRRC);
  endfunction

endpackage

// File: rtl/otter_cu_fsm.sv
// Multicycle OTTER control FSM: sequences FETCH/EXEC/WB, latches interrupts
// and enters the trap state only between instructions.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       intr,
  output logic       rst_out,
  output logic       PC_WE,
  output logic       RF_WE,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       memWE2,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec,
  output logic       intr_pending
);

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  logic       pend_q, pend_d;
  logic       take_intr;

  // A request arriving in the last cycle of an instruction is honoured at once.
  assign take_intr = pend_q | intr;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    pend_d     = pend_q;
    unique case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 4'd1;
        if (init_cnt_q == INIT_LAST) state_d = FETCH;
      end
      FETCH: begin
        pend_d  = take_intr;
        state_d = EXEC;
      end
      EXEC: begin
        pend_d = take_intr;
        if (opcode == LOAD) state_d = WB;
        else                state_d = take_intr ? INTR : FETCH;
      end
      WB: begin
        pend_d  = take_intr;
        state_d = take_intr ? INTR : FETCH;
      end
      INTR: begin
        pend_d  = 1'b0;
        state_d = FETCH;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) init_cnt_q <= 4'd0;
    else        init_cnt_q <= init_cnt_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

  always_comb begin
    rst_out   = 1'b0;
    PC_WE     = 1'b0;
    RF_WE     = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    memWE2    = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    unique case (state_q)
      INIT:  rst_out  = 1'b1;
      FETCH: memRDEN1 = 1'b1;
      EXEC: begin
        case (opcode)
          LOAD:   memRDEN2 = 1'b1;
          STORE: begin
            memWE2 = 1'b1;
            PC_WE  = 1'b1;
          end
          BRANCH: PC_WE = 1'b1;
          LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: begin
            RF_WE = 1'b1;
            PC_WE = 1'b1;
          end
          SYS: begin
            PC_WE = 1'b1;
            if (func3 == F3_MRET) mret_exec = 1'b1;
            else if (is_csr_rw(func3)) begin
              RF_WE  = 1'b1;
              csr_WE = 1'b1;
            end
          end
          // Undefined opcodes retire as a nop.
          default: PC_WE = 1'b1;
        endcase
      end
      WB: begin
        RF_WE = 1'b1;
        PC_WE = 1'b1;
      end
      INTR: begin
        int_taken = 1'b1;
        PC_WE     = 1'b1;
      end
      default: rst_out = 1'b1;
    endcase
  end

  assign intr_pending = pend_q;

endmodule
